// File: rtl/lif_pkg.sv
// Shared constants and helpers for the LIF neuron bank.
// Holds the post-spike reset-mode encodings and a width-generic saturating adder.
package lif_pkg;

    localparam logic LIF_RST_ZERO = 1'b0;
    localparam logic LIF_RST_SUB  = 1'b1;

    localparam int LIF_MAX_W = 32;

    // Unsigned add clamped to 2^width-1; callers zero-extend operands to LIF_MAX_W.
    function automatic logic [LIF_MAX_W-1:0] satAdd(
        input logic [LIF_MAX_W-1:0] a,
        input logic [LIF_MAX_W-1:0] b,
        input int                   width
    );
        logic [LIF_MAX_W:0] sum;
        logic [LIF_MAX_W:0] limit;
        sum   = {1'b0, a} + {1'b0, b};
        limit = ({{LIF_MAX_W{1'b0}}, 1'b1} << width) - {{LIF_MAX_W{1'b0}}, 1'b1};
        return (sum > limit) ? limit[LIF_MAX_W-1:0] : sum[LIF_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leaky integrate-and-fire rule for one neuron:
// (state, refractory count, current, config) -> (next state, next count, fire).
module lif_update
    import lif_pkg::*;
#(
    parameter int W     = 8,
    parameter int REF_W = 3
) (
    input  logic [W-1:0]     s_i,
    input  logic [REF_W-1:0] r_i,
    input  logic [W-1:0]     current_i,
    input  logic [W-1:0]     threshold_i,
    input  logic [2:0]       leak_shift_i,
    input  logic [REF_W-1:0] refrac_len_i,
    input  logic             reset_mode_i,
    output logic [W-1:0]     s_o,
    output logic [REF_W-1:0] r_o,
    output logic             fire_o
);

    logic [W-1:0] leak;
    logic [W-1:0] leaked;
    logic [W-1:0] n;

    // A refractory neuron only leaks; otherwise it integrates and may fire.
    always_comb begin
        leak   = (leak_shift_i == 3'd0) ? '0 : (s_i >> leak_shift_i);
        leaked = s_i - leak;
        n      = W'(satAdd(LIF_MAX_W'(leaked), LIF_MAX_W'(current_i), W));
        s_o    = leaked;
        r_o    = r_i;
        fire_o = 1'b0;
        if (r_i != '0) begin
            r_o = r_i - REF_W'(1);
        end else if (n >= threshold_i) begin
            fire_o = 1'b1;
            s_o    = (reset_mode_i == LIF_RST_SUB) ? (n - threshold_i) : '0;
            r_o    = refrac_len_i;
        end else begin
            s_o = n;
        end
    end

endmodule

// File: rtl/lif_neuron_bank.sv
// Time-multiplexed bank of LIF neurons sharing one lif_update datapath,
// visiting channels round-robin, one per enabled cycle.
module lif_neuron_bank
    import lif_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int REF_W = 3,
    parameter int CH_W  = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [W-1:0]     current,
    input  logic [W-1:0]     threshold,
    input  logic [2:0]       leak_shift,
    input  logic [REF_W-1:0] refrac_len,
    input  logic             reset_mode,
    output logic [CH_W-1:0]  ch_idx,
    output logic [W-1:0]     state_out,
    output logic             spike,
    output logic [CH_W-1:0]  spike_ch,
    output logic [N_CH-1:0]  spike_vec,
    output logic             frame_done
);

    logic [W-1:0]     state_q  [N_CH];
    logic [REF_W-1:0] refrac_q [N_CH];
    logic [CH_W-1:0]  chIdx_q, chIdx_d;
    logic [W-1:0]     stateOut_q;
    logic             spike_q;
    logic [CH_W-1:0]  spikeCh_q;
    logic [N_CH-1:0]  spikeVec_q, spikeVec_d;
    logic             frameDone_q;

    logic [W-1:0]     sNext;
    logic [REF_W-1:0] rNext;
    logic             fire;
    logic             lastCh;

    lif_update #(
        .W     (W),
        .REF_W (REF_W)
    ) u_update (
        .s_i          (state_q[chIdx_q]),
        .r_i          (refrac_q[chIdx_q]),
        .current_i    (current),
        .threshold_i  (threshold),
        .leak_shift_i (leak_shift),
        .refrac_len_i (refrac_len),
        .reset_mode_i (reset_mode),
        .s_o          (sNext),
        .r_o          (rNext),
        .fire_o       (fire)
    );

    // Channel 0 opens a new frame, so its update starts from a cleared spike vector.
    always_comb begin
        lastCh     = (chIdx_q == CH_W'(N_CH - 1));
        chIdx_d    = lastCh ? '0 : (chIdx_q + CH_W'(1));
        spikeVec_d = (chIdx_q == '0) ? '0 : spikeVec_q;
        if (fire) begin
            spikeVec_d = spikeVec_d | (N_CH'(1) << chIdx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= '0;
                refrac_q[i] <= '0;
            end
            chIdx_q     <= '0;
            stateOut_q  <= '0;
            spike_q     <= 1'b0;
            spikeCh_q   <= '0;
            spikeVec_q  <= '0;
            frameDone_q <= 1'b0;
        end else if (en) begin
            state_q[chIdx_q]  <= sNext;
            refrac_q[chIdx_q] <= rNext;
            chIdx_q           <= chIdx_d;
            stateOut_q        <= sNext;
            spike_q           <= fire;
            spikeCh_q         <= chIdx_q;
            spikeVec_q        <= spikeVec_d;
            frameDone_q       <= lastCh;
        end else begin
            spike_q     <= 1'b0;
            frameDone_q <= 1'b0;
        end
    end

    assign ch_idx     = chIdx_q;
    assign state_out  = stateOut_q;
    assign spike      = spike_q;
    assign spike_ch   = spikeCh_q;
    assign spike_vec  = spikeVec_q;
    assign frame_done = frameDone_q;

endmodule

// File: doc/lif_neuron_bank.md
# lif_neuron_bank

Parametrised, time-multiplexed bank of leaky integrate-and-fire neurons. One shared update datapath serves `N_CH` neuron channels in round-robin order, and each channel keeps its own membrane state and refractory counter. Threshold, leak strength, refractory length and post-spike reset mode are all runtime-configurable. It succeeds the single fixed LIF neuron behind the TinyTapeout top level and is instantiated there, with `N_CH`/`W` sized to fit the pin budget.

## Interface
Parameters:
- `N_CH`, default 4: number of neuron channels; must be ≥ 2.
- `W`, default 8: membrane/current width in bits.
- `REF_W`, default 3: refractory counter width.
- `CH_W`, default $clog2(N_CH): channel index width.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `en`, in, 1: advance one channel update per cycle when high.
- `current`, in, W: input current for channel `ch_idx`, sampled this cycle.
- `threshold`, in, W: firing threshold.
- `leak_shift`, in, 3: leak = state >> leak_shift; 0 = no leak.
- `refrac_len`, in, REF_W: refractory updates after a spike.
- `reset_mode`, in, 1: 0 = reset to zero, 1 = subtract threshold.
- `ch_idx`, out, CH_W: channel updated this cycle; tells the driver which current to present.
- `state_out`, out, W: new membrane state of the last updated channel, registered.
- `spike`, out, 1: one-cycle pulse, last updated channel fired.
- `spike_ch`, out, CH_W: channel that produced `state_out`/`spike`.
- `spike_vec`, out, N_CH: per-channel sticky spike flags, cleared at frame start.
- `frame_done`, out, 1: pulse, channel N_CH−1 updated.

## Operation
- Per enabled cycle, for channel c = `ch_idx`, with s = state[c] and r = refrac[c]:
  - leak term L = (leak_shift==0) ? 0 : s >> leak_shift.
  - If r ≠ 0: state[c] ← s − L; refrac[c] ← r − 1; no integration and no spike; `current` is ignored.
  - Else n = s − L + current, computed at W+1 bits and saturated to 2^W−1.
    - If n ≥ threshold: fire. state[c] ← 0 when reset_mode=0, otherwise n − threshold. refrac[c] ← refrac_len.
    - Otherwise state[c] ← n.
- threshold = 0: every non-refractory update fires.
- refrac_len = 0: the channel can fire again on its next update.
- `ch_idx` increments each enabled cycle and wraps from N_CH−1 to 0.
- `spike_vec` is cleared on the update of channel 0, then ORs in each spike of the frame. Channel 0's own spike is written into the cleared vector.
- `en` low:
  - all state, refrac and `ch_idx` hold.
  - `spike` and `frame_done` drive 0.
  - `state_out`, `spike_ch` and `spike_vec` hold.
- Config inputs are used combinationally on each update. A mid-frame change affects subsequent channels immediately, with no shadowing.

## Timing
- Reset (reset_n=0 at a clk edge) zeroes all state[], refrac[], `ch_idx`, `state_out`, `spike`, `spike_ch`, `spike_vec` and `frame_done`. Reset overrides `en`.
- Reset mid-frame: the next frame restarts at channel 0.
- `current` is sampled at the edge ending cycle t, where `ch_idx`=c. `state_out`, `spike` and `spike_ch`=c are valid in cycle t+1. Latency is 1 cycle.
- Each channel is updated once per N_CH enabled cycles.
- `frame_done` is high in the cycle after channel N_CH−1's update, coincident with that channel's `spike`.
- Max throughput: one channel update per cycle, with no stalls.

## Structure
- Package `lif_pkg` holds:
  - the reset-mode constants `LIF_RST_ZERO`=0 and `LIF_RST_SUB`=1.
  - a saturating-add function.
- Sub-module `lif_update` is the combinational datapath: (s, r, current, config) → (s', r', fire). This keeps the per-neuron rule reusable and unit-testable.
- The bank holds the state/refrac register arrays, the channel counter and the output registers.

## Test plan
- Leak-free integration, W=8, N_CH=4, threshold=100, leak_shift=0, refrac_len=0, reset_mode=0, current=30 on ch1 only:
  - ch1 state_out reads 30, 60, 90, then 0 with spike=1 and spike_ch=1 on its 4th update.
  - Other channels stay 0.
- Leak: ch0 current=0, starting state 64, leak_shift=2 → successive state_out 48, 36, 27, 21.
- Refractory window with refrac_len=2, current=200 ≥ threshold=100:
  - fires on update 1.
  - updates 2–3 show no spike and ignore current.
  - fires again on update 4.
- Subtract mode and saturation, reset_mode=1, threshold=100, current=250 from state 20:
  - n saturates to 255.
  - spike=1, state_out=155.
- Frame boundary and `en`:
  - `frame_done` pulses every 4 enabled cycles, and `spike_vec` reflects only the current frame.
  - Hold `en` low for 5 cycles mid-frame → `ch_idx` frozen, spike=0, and the frame resumes at the same channel.
- Reset mid-frame at ch_idx=2:
  - all outputs are 0 in the next cycle and `ch_idx`=0.
  - previously accumulated states are gone (all channels read 0).
